mult_dispatch: RTL and testbench

- Upstream feeder for the 8x8 ROM-based sequential multiplier (w, y, S in; result, PRONTO out).
- Accepts operand pairs over a valid/ready stream and buffers them in a small FIFO.
- Issues them to the multiplier one at a time: drives w/y, pulses S, waits for PRONTO.
- Captures each 16-bit product into an output register with valid/ready handshake.

---
 rtl/mult_dispatch_pkg.sv | 15 +
 rtl/mult_dispatch_sync_fifo.sv | 61 ++++++
 rtl/mult_dispatch.sv | 134 +++++++++++++
 tb/tb_mult_dispatch.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_dispatch_pkg.sv
// Shared types and defaults for the multiplier dispatcher.
// State encoding is fixed so debug taps can decode it directly.
package mult_dispatch_pkg;

    localparam int WIDTH_DEF   = 8;
    localparam int DEPTH_DEF   = 4;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/mult_dispatch_sync_fifo.sv
// Single-clock FIFO holding queued operand pairs.
// Pointers wrap naturally because DEPTH is a power of two.
module sync_fifo
    import mult_dispatch_pkg::*;
#(
    parameter int DW    = 2 * WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            din,
    output logic [DW-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];
    assign count   = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: a flushed FIFO is defined by count alone.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mult_dispatch.sv
// Feeds queued operand pairs to the sequential ROM multiplier one at a time
// and holds each product in an output register until the consumer takes it.
module mult_dispatch
    import mult_dispatch_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_w,
    input  logic [WIDTH-1:0]         in_y,
    output logic [WIDTH-1:0]         mul_w,
    output logic [WIDTH-1:0]         mul_y,
    output logic                     mul_S,
    input  logic [2*WIDTH-1:0]       mul_result,
    input  logic                     mul_pronto,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*WIDTH-1:0]       out_result,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t             state_q;
    state_t             state_d;
    logic [TW-1:0]      tmo_q;
    logic               seen_low_q;
    logic [2*WIDTH-1:0] head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               dispatch;
    logic               accept;
    logic               tmo_hit;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;

    sync_fifo #(
        .DW    (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (push),
        .pop   (dispatch),
        .din   ({in_w, in_y}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    // Dispatch only when the output slot is free or being freed this edge,
    // so a capture can never collide with an unread product.
    assign dispatch = (state_q == ST_IDLE) && !fifo_empty && (!out_valid || out_ready);

    // A PRONTO still high from the previous op is ignored until it has dropped once.
    assign accept  = (state_q == ST_WAIT) && mul_pronto && seen_low_q;
    assign tmo_hit = (state_q == ST_WAIT) && !accept && (tmo_q == TMO_LAST);

    assign mul_S = (state_q == ST_START);
    assign busy  = (state_q != ST_IDLE) || !fifo_empty;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (dispatch) state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT:  if (accept || tmo_hit) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mul_w <= '0;
            mul_y <= '0;
        end else if (dispatch) begin
            mul_w <= head[2*WIDTH-1:WIDTH];
            mul_y <= head[WIDTH-1:0];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tmo_q      <= '0;
            seen_low_q <= 1'b0;
        end else if (state_q == ST_START) begin
            tmo_q      <= '0;
            seen_low_q <= 1'b0;
        end else if (state_q == ST_WAIT) begin
            if (!tmo_hit)
                tmo_q <= tmo_q + 1'b1;
            if (!mul_pronto)
                seen_low_q <= 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            out_valid  <= 1'b0;
            out_result <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_result <= mul_result;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            err <= 1'b0;
        else if (tmo_hit)
            err <= 1'b1;
    end

endmodule

// File: tb/tb_mult_dispatch.sv
// Directed bench for mult_dispatch with a behavioural ROM-multiplier model
// whose PRONTO latency, stale-hold and silence can be steered per operation.
module tb_mult_dispatch;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_w;
    logic [7:0]  in_y;
    logic [7:0]  mul_w;
    logic [7:0]  mul_y;
    logic        mul_S;
    logic [15:0] mul_result;
    logic        mul_pronto;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        busy;
    logic [2:0]  count;
    logic        err;

    int total = 0;
    int bad   = 0;

    // multiplier model controls and observation
    int lat        = 5;
    int stale_hold = 0;
    bit never      = 1'b0;
    int cyc        = 0;
    int s_pulses   = 0;
    int s_cyc      = 0;

    mult_dispatch dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_w       (in_w),
        .in_y       (in_y),
        .mul_w      (mul_w),
        .mul_y      (mul_y),
        .mul_S      (mul_S),
        .mul_result (mul_result),
        .mul_pronto (mul_pronto),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy),
        .count      (count),
        .err        (err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Multiplier model: S is sampled mid-cycle, PRONTO/result change 1ns after the edge.
    initial begin
        bit         sflag;
        bit         active;
        int         k;
        logic [7:0] mw;
        logic [7:0] my;
        active     = 1'b0;
        k          = 0;
        mw         = '0;
        my         = '0;
        mul_pronto = 1'b0;
        mul_result = '0;
        forever begin
            @(negedge CLK);
            sflag = mul_S;
            if (sflag) begin
                mw = mul_w;
                my = mul_y;
            end
            @(posedge CLK);
            #1;
            cyc++;
            if (sflag) begin
                s_pulses++;
                s_cyc  = cyc;
                k      = 1;
                active = 1'b1;
            end else if (active) begin
                k++;
            end
            if (active && k > stale_hold) begin
                if (!never && k >= lat) begin
                    mul_pronto = 1'b1;
                    mul_result = 16'(mw) * 16'(my);
                end else begin
                    mul_pronto = 1'b0;
                end
            end
        end
    end

    task automatic push(input logic [7:0] w, input logic [7:0] y);
        int n;
        @(negedge CLK);
        in_valid = 1'b1;
        in_w     = w;
        in_y     = y;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (!in_ready)
            check("push_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [15:0] exp);
        int n;
        n = 0;
        @(negedge CLK);
        while (!out_valid && n < 300) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_result"}, 32'(out_result), 32'(exp));
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        out_ready = 1'b0;
        check({tag, "_clear"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int p0;
        int c;
        int n;

        RESET     = 1'b1;
        in_valid  = 1'b0;
        in_w      = '0;
        in_y      = '0;
        out_ready = 1'b0;

        #12;
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_mul_S", 32'(mul_S), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge CLK);
        RESET = 1'b0;

        // single op and dispatch latency
        p0 = s_pulses;
        push(8'd6, 8'd10);
        @(negedge CLK);
        check("lat_s_before", 32'(mul_S), 32'd0);
        @(negedge CLK);
        check("lat_s_pulse", 32'(mul_S), 32'd1);
        check("lat_mul_w", 32'(mul_w), 32'd6);
        check("lat_mul_y", 32'(mul_y), 32'd10);
        @(negedge CLK);
        check("lat_s_after", 32'(mul_S), 32'd0);
        get_result("single", 16'd60);
        check("single_pulses", 32'(s_pulses - p0), 32'd1);
        check("single_w_stable", 32'(mul_w), 32'd6);

        // fill with output back-pressure
        push(8'd3, 8'd4);
        push(8'd255, 8'd255);
        push(8'd0, 8'd9);
        push(8'd1, 8'd1);
        push(8'd7, 8'd7);
        n = 0;
        @(negedge CLK);
        while (!out_valid && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("fill_count", 32'(count), 32'd4);
        check("fill_in_ready", 32'(in_ready), 32'd0);
        check("fill_busy", 32'(busy), 32'd1);
        get_result("fill0", 16'd12);
        get_result("fill1", 16'd65025);
        get_result("fill2", 16'd0);
        get_result("fill3", 16'd1);
        get_result("fill4", 16'd49);
        check("fill_empty", 32'(count), 32'd0);

        // stale PRONTO from the previous op must be ignored
        push(8'd3, 8'd5);
        get_result("pre_stale", 16'd15);
        stale_hold = 2;
        push(8'd2, 8'd4);
        get_result("stale", 16'd8);
        stale_hold = 0;

        // timeout drops the op, the next queued op still completes
        never = 1'b1;
        p0    = s_pulses;
        push(8'd5, 8'd5);
        push(8'd2, 8'd3);
        n = 0;
        while (s_pulses == p0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("tmo_s_seen", 32'(s_pulses != p0), 32'd1);
        c = s_cyc;
        n = 0;
        while (cyc < c + 63 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("tmo_err_early", 32'(err), 32'd0);
        @(negedge CLK);
        check("tmo_err_set", 32'(err), 32'd1);
        check("tmo_no_valid", 32'(out_valid), 32'd0);
        never = 1'b0;
        get_result("after_tmo", 16'd6);
        check("err_sticky", 32'(err), 32'd1);

        // asynchronous reset mid-WAIT with two pairs queued
        never = 1'b1;
        push(8'd4, 8'd4);
        push(8'd5, 8'd6);
        push(8'd7, 8'd8);
        repeat (4) @(negedge CLK);
        check("pre_rst_count", 32'(count), 32'd2);
        #2;
        RESET = 1'b1;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_mul_S", 32'(mul_S), 32'd0);
        check("arst_mul_w", 32'(mul_w), 32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_result", 32'(out_result), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        never = 1'b0;
        check("post_rst_count", 32'(count), 32'd0);
        push(8'd9, 8'd9);
        get_result("after_rst", 16'd81);
        check("final_count", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
